// File: rtl/bwt_req_issue_pkg.sv
// bwt_req_issue_pkg: shared pipeline constants for the backward-control request issue path
package bwt_req_issue_pkg;
  localparam int ADDR_W = 42;
  typedef enum logic {ISSUE_K = 1'b0, ISSUE_L = 1'b1} issue_state_t;
  localparam logic HALF_K = 1'b0;
  localparam logic HALF_L = 1'b1;
endpackage

// File: rtl/bwt_req_issue_req_fifo.sv
// req_fifo: parameterised synchronous circular FIFO with a combinational head view
module req_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  // a pop frees the head slot in the same cycle, so a full FIFO can still take a push
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/bwt_req_issue.sv
// bwt_req_issue: queues k/l lookup requests and issues each as two memory requests, k then l
`ifndef READ_NUM_WIDTH
`define READ_NUM_WIDTH 8
`endif
module bwt_req_issue
  import bwt_req_issue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SKID = 4,
  parameter int RN_W = `READ_NUM_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     request_valid,
  input  logic [RN_W-1:0]          read_num,
  input  logic [ADDR_W-1:0]        addr_k,
  input  logic [ADDR_W-1:0]        addr_l,
  output logic                     stall,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [RN_W:0]            mem_req_tag,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err
);
  localparam int EW = RN_W + 2 * ADDR_W;
  localparam logic [$clog2(DEPTH):0] STALL_AT = ($clog2(DEPTH)+1)'(DEPTH - SKID);
  logic [EW-1:0] head;
  logic full, empty, hs, pop;
  logic [$clog2(DEPTH):0] count;
  issue_state_t state, state_nxt;
  req_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(request_valid),
    .pop(pop),
    .din({read_num, addr_k, addr_l}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign mem_req_valid = ~empty;
  assign hs = mem_req_valid & mem_req_ready;
  assign pop = hs & (state == ISSUE_L);
  assign occupancy = count;
  assign stall = count >= STALL_AT;
  always_ff @(posedge clk) state <= rst ? ISSUE_K : state_nxt;
  always_comb begin
    state_nxt = state;
    mem_req_addr = head[2*ADDR_W-1 -: ADDR_W];
    mem_req_tag = {head[EW-1 -: RN_W], HALF_K};
    if (hs) state_nxt = (state == ISSUE_K) ? ISSUE_L : ISSUE_K;
    if (state == ISSUE_L) begin
      mem_req_addr = head[ADDR_W-1:0];
      mem_req_tag = {head[EW-1 -: RN_W], HALF_L};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) overflow_err <= 1'b0;
    else if (request_valid & full & ~pop) overflow_err <= 1'b1;
  end
endmodule
